// File: rtl/score_ram.sv
// score_ram: DEPTH x DATA_W score store with a zero-clear sweep after reset and a READ_LAT-deep read pipeline.
// Optional build macro SCORE_RAM_WFWD_EN selects write-first forwarding for same-edge, same-address read+write.
module score_ram #(
    parameter int DATA_W   = 7,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RAM_R,
    input  logic              RAM_W,
    input  logic [ADDR_W-1:0] RAM_addr,
    input  logic [DATA_W-1:0] RAM_wdata,
    output logic [DATA_W-1:0] RAM_data,
    output logic              rd_valid,
    output logic              init_done
);

    typedef enum logic {CLEAR, READY} state_t;

    // One extra counter bit so DEPTH = 2**ADDR_W finishes without wrapping.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W:0]   cnt_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q [READ_LAT];
    logic [READ_LAT-1:0] rd_vld_q;

    logic              ready;
    logic              addr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_cap_d;

    assign ready   = (state_q == READY);
    assign addr_ok = ({1'b0, RAM_addr} < DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            init_done <= 1'b0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_C) begin
                state_q   <= READY;
                init_done <= 1'b1;
            end
        end
    end

    // The sweep owns the write port until it finishes; requests are ignored meanwhile.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = RAM_addr;
        mem_wdata = RAM_wdata;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
        end else if (RAM_W && addr_ok) begin
            mem_we = 1'b1;
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_comb begin
        rd_cap_d = '0;
        if (addr_ok) begin
            rd_cap_d = mem[RAM_addr];
`ifdef SCORE_RAM_WFWD_EN
            if (RAM_W) begin
                rd_cap_d = RAM_wdata;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q[0] <= rd_cap_d;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_data_q[i] <= rd_data_q[i-1];
        end
    end

    // Valid bits travel alongside the data; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= '0;
            rd_valid <= 1'b0;
            RAM_data <= '0;
        end else begin
            rd_vld_q[0] <= ready && RAM_R;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end
            rd_valid <= rd_vld_q[READ_LAT-1];
            if (rd_vld_q[READ_LAT-1]) begin
                RAM_data <= rd_data_q[READ_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_score_ram.sv
// Directed bench for score_ram: three instances (32/lat1, 24/lat3, 32/lat2) share one request stream.
// Expected values are hand-written per instance, honouring SCORE_RAM_WFWD_EN when it is defined.
module tb_score_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r = 1'b0;
    logic       w = 1'b0;
    logic [4:0] addr = '0;
    logic [6:0] wdata = '0;

    logic [6:0] data_a, data_b, data_c;
    logic       vld_a, vld_b, vld_c;
    logic       done_a, done_b, done_c;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef SCORE_RAM_WFWD_EN
    localparam logic [6:0] COLL_EXP = 7'd77;
`else
    localparam logic [6:0] COLL_EXP = 7'd40;
`endif

    score_ram #(.DATA_W(7), .ADDR_W(5), .DEPTH(32), .READ_LAT(1)) u_a (
        .clk(clk), .rst(rst), .RAM_R(r), .RAM_W(w), .RAM_addr(addr), .RAM_wdata(wdata),
        .RAM_data(data_a), .rd_valid(vld_a), .init_done(done_a));

    score_ram #(.DATA_W(7), .ADDR_W(5), .DEPTH(24), .READ_LAT(3)) u_b (
        .clk(clk), .rst(rst), .RAM_R(r), .RAM_W(w), .RAM_addr(addr), .RAM_wdata(wdata),
        .RAM_data(data_b), .rd_valid(vld_b), .init_done(done_b));

    score_ram #(.DATA_W(7), .ADDR_W(5), .DEPTH(32), .READ_LAT(2)) u_c (
        .clk(clk), .rst(rst), .RAM_R(r), .RAM_W(w), .RAM_addr(addr), .RAM_wdata(wdata),
        .RAM_data(data_c), .rd_valid(vld_c), .init_done(done_c));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int e_a = 0, e_b = 0, e_c = 0;
        logic saw_v = 1'b0;
        rst = 1'b1;
        step();
        step();
        total_cnt++; if (data_a !== 7'd0) $display("FAIL rst_data_a: got %0d expected 0", data_a); else pass_cnt++;
        total_cnt++; if (data_b !== 7'd0) $display("FAIL rst_data_b: got %0d expected 0", data_b); else pass_cnt++;
        total_cnt++; if (data_c !== 7'd0) $display("FAIL rst_data_c: got %0d expected 0", data_c); else pass_cnt++;
        total_cnt++; if ({vld_a, vld_b, vld_c} !== 3'b000) $display("FAIL rst_valid: got %b expected 000", {vld_a, vld_b, vld_c}); else pass_cnt++;
        total_cnt++; if ({done_a, done_b, done_c} !== 3'b000) $display("FAIL rst_done: got %b expected 000", {done_a, done_b, done_c}); else pass_cnt++;
        // Requests during the sweep must be ignored.
        rst = 1'b0; r = 1'b1; w = 1'b1; addr = 5'd0; wdata = 7'd99;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 10) begin r = 1'b0; w = 1'b0; end
            if (vld_a || vld_b || vld_c) saw_v = 1'b1;
            if (done_a && e_a == 0) e_a = i;
            if (done_b && e_b == 0) e_b = i;
            if (done_c && e_c == 0) e_c = i;
        end
        total_cnt++; if (e_a != 32) $display("FAIL sweep_edges_a: got %0d expected 32", e_a); else pass_cnt++;
        total_cnt++; if (e_b != 24) $display("FAIL sweep_edges_b: got %0d expected 24", e_b); else pass_cnt++;
        total_cnt++; if (e_c != 32) $display("FAIL sweep_edges_c: got %0d expected 32", e_c); else pass_cnt++;
        total_cnt++; if (saw_v !== 1'b0) $display("FAIL sweep_no_valid: got %b expected 0", saw_v); else pass_cnt++;
    endtask

    task automatic test_clear_contents();
        r = 1'b1; addr = 5'd0;
        step();
        r = 1'b0;
        step();
        total_cnt++; if ({vld_a, data_a} !== {1'b1, 7'd0}) $display("FAIL clr_read_a: got v=%b d=%0d expected v=1 d=0", vld_a, data_a); else pass_cnt++;
        total_cnt++; if (vld_c !== 1'b0) $display("FAIL clr_early_c: got v=%b expected v=0", vld_c); else pass_cnt++;
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, 7'd0}) $display("FAIL clr_read_c: got v=%b d=%0d expected v=1 d=0", vld_c, data_c); else pass_cnt++;
        total_cnt++; if (vld_a !== 1'b0) $display("FAIL clr_pulse_a: got v=%b expected v=0", vld_a); else pass_cnt++;
        step();
        total_cnt++; if ({vld_b, data_b} !== {1'b1, 7'd0}) $display("FAIL clr_read_b: got v=%b d=%0d expected v=1 d=0", vld_b, data_b); else pass_cnt++;
    endtask

    task automatic test_hold();
        logic ok = 1'b1;
        w = 1'b1; addr = 5'd5; wdata = 7'd93;
        step();
        w = 1'b0; r = 1'b1;
        step();
        r = 1'b0;
        step();
        total_cnt++; if ({vld_a, data_a} !== {1'b1, 7'd93}) $display("FAIL hold_read_a: got v=%b d=%0d expected v=1 d=93", vld_a, data_a); else pass_cnt++;
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, 7'd93}) $display("FAIL hold_read_c: got v=%b d=%0d expected v=1 d=93", vld_c, data_c); else pass_cnt++;
        step();
        total_cnt++; if ({vld_b, data_b} !== {1'b1, 7'd93}) $display("FAIL hold_read_b: got v=%b d=%0d expected v=1 d=93", vld_b, data_b); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (data_a !== 7'd93 || data_b !== 7'd93 || data_c !== 7'd93 || vld_a || vld_b || vld_c) ok = 1'b0;
        end
        total_cnt++; if (ok !== 1'b1) $display("FAIL hold_idle: got d=%0d/%0d/%0d expected 93 held with no valid", data_a, data_b, data_c); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v [3] = '{7'd10, 7'd20, 7'd30};
        int ka, kb, kc;
        for (int j = 0; j < 3; j++) begin
            w = 1'b1; addr = 5'(j); wdata = exp_v[j];
            step();
        end
        w = 1'b0;
        for (int j = 0; j < 8; j++) begin
            r = (j < 3); addr = 5'(j);
            step();
            ka = j - 1; kb = j - 3; kc = j - 2;
            total_cnt++; if (vld_a !== (ka >= 0 && ka < 3)) $display("FAIL b2b_valid_a j=%0d: got %b expected %b", j, vld_a, (ka >= 0 && ka < 3)); else pass_cnt++;
            total_cnt++; if (vld_b !== (kb >= 0 && kb < 3)) $display("FAIL b2b_valid_b j=%0d: got %b expected %b", j, vld_b, (kb >= 0 && kb < 3)); else pass_cnt++;
            total_cnt++; if (vld_c !== (kc >= 0 && kc < 3)) $display("FAIL b2b_valid_c j=%0d: got %b expected %b", j, vld_c, (kc >= 0 && kc < 3)); else pass_cnt++;
            if (ka >= 0 && ka < 3) begin
                total_cnt++; if (data_a !== exp_v[ka]) $display("FAIL b2b_data_a j=%0d: got %0d expected %0d", j, data_a, exp_v[ka]); else pass_cnt++;
            end
            if (kb >= 0 && kb < 3) begin
                total_cnt++; if (data_b !== exp_v[kb]) $display("FAIL b2b_data_b j=%0d: got %0d expected %0d", j, data_b, exp_v[kb]); else pass_cnt++;
            end
            if (kc >= 0 && kc < 3) begin
                total_cnt++; if (data_c !== exp_v[kc]) $display("FAIL b2b_data_c j=%0d: got %0d expected %0d", j, data_c, exp_v[kc]); else pass_cnt++;
            end
        end
        r = 1'b0;
    endtask

    task automatic test_rw_collision();
        w = 1'b1; addr = 5'd3; wdata = 7'd40;
        step();
        r = 1'b1; wdata = 7'd77;
        step();
        r = 1'b0; w = 1'b0;
        step();
        total_cnt++; if ({vld_a, data_a} !== {1'b1, COLL_EXP}) $display("FAIL coll_a: got v=%b d=%0d expected v=1 d=%0d", vld_a, data_a, COLL_EXP); else pass_cnt++;
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, COLL_EXP}) $display("FAIL coll_c: got v=%b d=%0d expected v=1 d=%0d", vld_c, data_c, COLL_EXP); else pass_cnt++;
        step();
        total_cnt++; if ({vld_b, data_b} !== {1'b1, COLL_EXP}) $display("FAIL coll_b: got v=%b d=%0d expected v=1 d=%0d", vld_b, data_b, COLL_EXP); else pass_cnt++;
        r = 1'b1;
        step();
        r = 1'b0;
        step();
        total_cnt++; if ({vld_a, data_a} !== {1'b1, 7'd77}) $display("FAIL coll_after_a: got v=%b d=%0d expected v=1 d=77", vld_a, data_a); else pass_cnt++;
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, 7'd77}) $display("FAIL coll_after_c: got v=%b d=%0d expected v=1 d=77", vld_c, data_c); else pass_cnt++;
        step();
        total_cnt++; if ({vld_b, data_b} !== {1'b1, 7'd77}) $display("FAIL coll_after_b: got v=%b d=%0d expected v=1 d=77", vld_b, data_b); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [6:0] exp_m [24];
        int k;
        for (int i = 0; i < 24; i++) exp_m[i] = 7'd0;
        exp_m[0] = 7'd10; exp_m[1] = 7'd20; exp_m[2] = 7'd30; exp_m[3] = 7'd77; exp_m[5] = 7'd93;
        w = 1'b1; addr = 5'd25; wdata = 7'd50;
        step();
        w = 1'b0; r = 1'b1;
        step();
        r = 1'b0;
        step();
        total_cnt++; if ({vld_a, data_a} !== {1'b1, 7'd50}) $display("FAIL oor_a: got v=%b d=%0d expected v=1 d=50", vld_a, data_a); else pass_cnt++;
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, 7'd50}) $display("FAIL oor_c: got v=%b d=%0d expected v=1 d=50", vld_c, data_c); else pass_cnt++;
        step();
        total_cnt++; if ({vld_b, data_b} !== {1'b1, 7'd0}) $display("FAIL oor_b: got v=%b d=%0d expected v=1 d=0", vld_b, data_b); else pass_cnt++;
        for (int j = 0; j < 27; j++) begin
            r = (j < 24); addr = 5'(j);
            step();
            k = j - 3;
            if (k >= 0 && k < 24) begin
                total_cnt++; if ({vld_b, data_b} !== {1'b1, exp_m[k]}) $display("FAIL oor_entry_b[%0d]: got v=%b d=%0d expected v=1 d=%0d", k, vld_b, data_b, exp_m[k]); else pass_cnt++;
            end
        end
        r = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic saw_v = 1'b0;
        int e_c = 0;
        r = 1'b1; addr = 5'd5;
        step();
        r = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++; if ({vld_c, data_c, done_c} !== {1'b0, 7'd0, 1'b0}) $display("FAIL midrst_c: got v=%b d=%0d done=%b expected v=0 d=0 done=0", vld_c, data_c, done_c); else pass_cnt++;
        total_cnt++; if ({vld_a, data_a} !== {1'b0, 7'd0}) $display("FAIL midrst_a: got v=%b d=%0d expected v=0 d=0", vld_a, data_a); else pass_cnt++;
        step();
        step();
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (vld_c || vld_a) saw_v = 1'b1;
            if (done_c && e_c == 0) e_c = i;
        end
        total_cnt++; if (saw_v !== 1'b0) $display("FAIL midrst_no_valid: got %b expected 0", saw_v); else pass_cnt++;
        total_cnt++; if (e_c != 32) $display("FAIL midrst_sweep_c: got %0d expected 32", e_c); else pass_cnt++;
        r = 1'b1; addr = 5'd5;
        step();
        r = 1'b0;
        step();
        step();
        total_cnt++; if ({vld_c, data_c} !== {1'b1, 7'd0}) $display("FAIL midrst_cleared_c: got v=%b d=%0d expected v=1 d=0", vld_c, data_c); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clear_contents();
        test_hold();
        test_back_to_back();
        test_rw_collision();
        test_out_of_range();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
